// File: rtl/instruction_byte_loader_if.sv
// Handshake bundle between the prefetch queue, the byte loader and the
// execution sequencer. The master side is the loader itself: it drives the
// pop strobe and the assembled record, and it observes the queue head plus
// the flush/ack controls.
interface instruction_byte_loader_if #(
    parameter int LEN_WIDTH = 4
) ();
    // prefetch queue side
    logic [7:0]           prefetchTop;
    logic                 prefetchEmpty;
    logic                 advanceTop;
    // control
    logic                 flush;
    // execution sequencer side
    logic                 inst_valid;
    logic                 inst_ack;
    logic [7:0]           opcode;
    logic [7:0]           modrm;
    logic                 has_modrm;
    logic [15:0]          disp;
    logic [31:0]          imm;
    logic                 seg_ovr_valid;
    logic [1:0]           seg_ovr;
    logic [1:0]           rep;
    logic                 lock;
    logic [LEN_WIDTH-1:0] inst_len;

    modport master (
        input  prefetchTop, prefetchEmpty, flush, inst_ack,
        output advanceTop, inst_valid, opcode, modrm, has_modrm, disp, imm,
               seg_ovr_valid, seg_ovr, rep, lock, inst_len
    );

    modport slave (
        output prefetchTop, prefetchEmpty, flush, inst_ack,
        input  advanceTop, inst_valid, opcode, modrm, has_modrm, disp, imm,
               seg_ovr_valid, seg_ovr, rep, lock, inst_len
    );
endinterface

// File: rtl/instruction_byte_loader.sv
// 8088 instruction byte loader: pops bytes from the prefetch queue one at a
// time (at most one byte every two cycles), decodes prefixes, opcode, ModRM,
// displacement and immediate, and holds the finished record until the
// execution sequencer acknowledges it.
module instruction_byte_loader #(
    parameter int LEN_WIDTH = 4
) (
    input  logic                        CLKx4,
    input  logic                        RESET,
    instruction_byte_loader_if.master   bus
);

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        MODRM    = 3'd1,
        DISP_LO  = 3'd2,
        DISP_HI  = 3'd3,
        IMM      = 3'd4,
        WAIT_POP = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Opcodes that are followed by a ModRM byte.
    function automatic logic needs_modrm(input logic [7:0] op);
        logic r;
        casez (op)
            8'b00??_?0??: r = 1'b1;   // ALU r/m forms in 00-3F
            8'b1000_????: r = 1'b1;   // 80-8F
            8'b1100_01??: r = 1'b1;   // C4-C7
            8'b1101_00??: r = 1'b1;   // D0-D3 shifts
            8'b1101_1???: r = 1'b1;   // D8-DF escape
            8'hF6, 8'hF7,
            8'hFE, 8'hFF: r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    // Number of immediate bytes; reg_f is ModRM[5:3] (only F6/F7 care).
    function automatic logic [2:0] imm_count(input logic [7:0] op,
                                             input logic [2:0] reg_f);
        logic [2:0] n;
        casez (op)
            8'h9A, 8'hEA: n = 3'd4;
            8'b00??_?101, 8'h81, 8'b1010_00??, 8'hA9, 8'b1011_1???,
            8'hC2, 8'hCA, 8'hE8, 8'hE9, 8'hC7: n = 3'd2;
            8'hF7: n = (reg_f == 3'b000) ? 3'd2 : 3'd0;
            8'b00??_?100, 8'h80, 8'h82, 8'h83, 8'b0111_????, 8'hA8,
            8'b1011_0???, 8'hCD, 8'hD4, 8'hD5, 8'b1110_0???, 8'hEB,
            8'hC6: n = 3'd1;
            8'hF6: n = (reg_f == 3'b000) ? 3'd1 : 3'd0;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    state_t               state_q, state_d;
    state_t               ret_q, ret_d;
    logic                 adv_q, adv_d;
    logic                 valid_q, valid_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [7:0]           modrm_q, modrm_d;
    logic                 has_modrm_q, has_modrm_d;
    logic [15:0]          disp_q, disp_d;
    logic [31:0]          imm_q, imm_d;
    logic                 seg_valid_q, seg_valid_d;
    logic [1:0]           seg_q, seg_d;
    logic [1:0]           rep_q, rep_d;
    logic                 lock_q, lock_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 disp_two_q, disp_two_d;  // displacement is 16-bit
    logic [2:0]           imm_rem_q, imm_rem_d;    // immediate bytes still to fetch
    logic [1:0]           imm_idx_q, imm_idx_d;    // next immediate byte lane

    logic [LEN_WIDTH-1:0] len_inc_s;
    logic [2:0]           cnt_s;
    logic [7:0]           top_s;

    assign top_s     = bus.prefetchTop;
    assign len_inc_s = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);

    // Next-state and next-record computation for the fetch/decode sequence.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        adv_d       = 1'b0;
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        modrm_d     = modrm_q;
        has_modrm_d = has_modrm_q;
        disp_d      = disp_q;
        imm_d       = imm_q;
        seg_valid_d = seg_valid_q;
        seg_d       = seg_q;
        rep_d       = rep_q;
        lock_d      = lock_q;
        len_d       = len_q;
        disp_two_d  = disp_two_q;
        imm_rem_d   = imm_rem_q;
        imm_idx_d   = imm_idx_q;
        cnt_s       = 3'd0;

        if (bus.flush || ((state_q == DONE) && bus.inst_ack)) begin
            // Flush beats everything, including a pop that would happen now.
            state_d     = FETCH_OP;
            ret_d       = FETCH_OP;
            valid_d     = 1'b0;
            opcode_d    = 8'h00;
            modrm_d     = 8'h00;
            has_modrm_d = 1'b0;
            disp_d      = 16'h0000;
            imm_d       = 32'h0000_0000;
            seg_valid_d = 1'b0;
            seg_d       = 2'b00;
            rep_d       = 2'b00;
            lock_d      = 1'b0;
            len_d       = '0;
            disp_two_d  = 1'b0;
            imm_rem_d   = 3'd0;
            imm_idx_d   = 2'd0;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (!bus.prefetchEmpty) begin
                        adv_d   = 1'b1;
                        state_d = WAIT_POP;
                        len_d   = len_inc_s;
                        ret_d   = FETCH_OP;
                        case (top_s)
                            8'h26, 8'h2E, 8'h36, 8'h3E: begin
                                seg_valid_d = 1'b1;
                                seg_d       = top_s[4:3];
                            end
                            8'hF0:   lock_d = 1'b1;
                            8'hF2:   rep_d  = 2'b10;
                            8'hF3:   rep_d  = 2'b11;
                            default: begin
                                opcode_d = top_s;
                                cnt_s    = imm_count(top_s, 3'b000);
                                if (needs_modrm(top_s)) begin
                                    ret_d = MODRM;
                                end else if (cnt_s != 3'd0) begin
                                    ret_d     = IMM;
                                    imm_rem_d = cnt_s;
                                    imm_idx_d = 2'd0;
                                end else begin
                                    ret_d = DONE;
                                end
                            end
                        endcase
                    end else begin
                        state_d = FETCH_OP;
                    end
                end
                MODRM: begin
                    if (!bus.prefetchEmpty) begin
                        adv_d       = 1'b1;
                        state_d     = WAIT_POP;
                        len_d       = len_inc_s;
                        modrm_d     = top_s;
                        has_modrm_d = 1'b1;
                        cnt_s       = imm_count(opcode_q, top_s[5:3]);
                        imm_rem_d   = cnt_s;
                        imm_idx_d   = 2'd0;
                        case (top_s[7:6])
                            2'b00: begin
                                if (top_s[2:0] == 3'b110) begin
                                    disp_two_d = 1'b1;
                                    ret_d      = DISP_LO;
                                end else begin
                                    ret_d = (cnt_s != 3'd0) ? IMM : DONE;
                                end
                            end
                            2'b01: begin
                                disp_two_d = 1'b0;
                                ret_d      = DISP_LO;
                            end
                            2'b10: begin
                                disp_two_d = 1'b1;
                                ret_d      = DISP_LO;
                            end
                            default: ret_d = (cnt_s != 3'd0) ? IMM : DONE;
                        endcase
                    end else begin
                        state_d = MODRM;
                    end
                end
                DISP_LO: begin
                    if (!bus.prefetchEmpty) begin
                        adv_d   = 1'b1;
                        state_d = WAIT_POP;
                        len_d   = len_inc_s;
                        if (disp_two_q) begin
                            disp_d = {8'h00, top_s};
                            ret_d  = DISP_HI;
                        end else begin
                            disp_d = {{8{top_s[7]}}, top_s};
                            ret_d  = (imm_rem_q != 3'd0) ? IMM : DONE;
                        end
                    end else begin
                        state_d = DISP_LO;
                    end
                end
                DISP_HI: begin
                    if (!bus.prefetchEmpty) begin
                        adv_d   = 1'b1;
                        state_d = WAIT_POP;
                        len_d   = len_inc_s;
                        disp_d  = {top_s, disp_q[7:0]};
                        ret_d   = (imm_rem_q != 3'd0) ? IMM : DONE;
                    end else begin
                        state_d = DISP_HI;
                    end
                end
                IMM: begin
                    if (!bus.prefetchEmpty) begin
                        adv_d   = 1'b1;
                        state_d = WAIT_POP;
                        len_d   = len_inc_s;
                        imm_d[{imm_idx_q, 3'b000} +: 8] = top_s;
                        imm_idx_d = imm_idx_q + 2'd1;
                        imm_rem_d = imm_rem_q - 3'd1;
                        ret_d     = (imm_rem_q == 3'd1) ? DONE : IMM;
                    end else begin
                        state_d = IMM;
                    end
                end
                WAIT_POP: begin
                    // Queue head is settling after the pop; never pop here.
                    state_d = ret_q;
                    valid_d = (ret_q == DONE);
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = FETCH_OP;
                    ret_d   = FETCH_OP;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and record registers with synchronous reset.
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            state_q     <= FETCH_OP;
            ret_q       <= FETCH_OP;
            adv_q       <= 1'b0;
            valid_q     <= 1'b0;
            opcode_q    <= 8'h00;
            modrm_q     <= 8'h00;
            has_modrm_q <= 1'b0;
            disp_q      <= 16'h0000;
            imm_q       <= 32'h0000_0000;
            seg_valid_q <= 1'b0;
            seg_q       <= 2'b00;
            rep_q       <= 2'b00;
            lock_q      <= 1'b0;
            len_q       <= '0;
            disp_two_q  <= 1'b0;
            imm_rem_q   <= 3'd0;
            imm_idx_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            adv_q       <= adv_d;
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            modrm_q     <= modrm_d;
            has_modrm_q <= has_modrm_d;
            disp_q      <= disp_d;
            imm_q       <= imm_d;
            seg_valid_q <= seg_valid_d;
            seg_q       <= seg_d;
            rep_q       <= rep_d;
            lock_q      <= lock_d;
            len_q       <= len_d;
            disp_two_q  <= disp_two_d;
            imm_rem_q   <= imm_rem_d;
            imm_idx_q   <= imm_idx_d;
        end
    end

    assign bus.advanceTop    = adv_q;
    assign bus.inst_valid    = valid_q;
    assign bus.opcode        = opcode_q;
    assign bus.modrm         = modrm_q;
    assign bus.has_modrm     = has_modrm_q;
    assign bus.disp          = disp_q;
    assign bus.imm           = imm_q;
    assign bus.seg_ovr_valid = seg_valid_q;
    assign bus.seg_ovr       = seg_q;
    assign bus.rep           = rep_q;
    assign bus.lock          = lock_q;
    assign bus.inst_len      = len_q;

endmodule

// File: tb/tb_instruction_byte_loader.sv
// Bench for instruction_byte_loader: a byte-queue model of the prefetch
// queue feeds the DUT, and a decoder model turns the byte stream into the
// records the DUT must present.
module tb_instruction_byte_loader;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  modrm;
        logic        has_modrm;
        logic [15:0] disp;
        logic [31:0] imm;
        logic        segv;
        logic [1:0]  seg;
        logic [1:0]  rep;
        logic        lock;
        logic [3:0]  len;
    } rec_t;

    logic CLKx4 = 1'b0;
    logic RESET = 1'b1;
    always #5 CLKx4 = ~CLKx4;

    instruction_byte_loader_if #(.LEN_WIDTH(4)) bus ();
    instruction_byte_loader #(.LEN_WIDTH(4)) dut (.CLKx4(CLKx4), .RESET(RESET), .bus(bus));

    logic [7:0] pq[$];
    rec_t       exp_q[$];
    logic [7:0] dq[$];
    int   vectors = 0;
    int   errors  = 0;
    logic prev_adv = 1'b0;
    logic was_valid = 1'b0;
    logic hold = 1'b0;
    logic auto_ack = 1'b0;
    logic auto_hold = 1'b0;

    function automatic logic is_prefix(input logic [7:0] b);
        return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};
    endfunction

    // Reference decoder: one instruction from the front of b.
    function automatic rec_t decode(input logic [7:0] b [32], output int used);
        rec_t r;
        int i;
        int dn;
        int inn;
        logic [7:0] op;
        logic [7:0] m;
        r = '0;
        i = 0;
        m = 8'h00;
        while (i < 24 && is_prefix(b[i])) begin
            if (b[i] == 8'hF0) r.lock = 1'b1;
            else if (b[i] == 8'hF2) r.rep = 2'b10;
            else if (b[i] == 8'hF3) r.rep = 2'b11;
            else begin r.segv = 1'b1; r.seg = b[i][4:3]; end
            i++;
        end
        op = b[i];
        i++;
        r.opcode = op;
        if ((op <= 8'h3F && op[2] == 1'b0) || op inside {[8'h80:8'h8F], [8'hC4:8'hC7],
            [8'hD0:8'hD3], [8'hD8:8'hDF], 8'hF6, 8'hF7, 8'hFE, 8'hFF}) begin
            m = b[i];
            i++;
            r.modrm = m;
            r.has_modrm = 1'b1;
            if (m[7:6] == 2'd0 && m[2:0] == 3'd6) dn = 2;
            else if (m[7:6] == 2'd1) dn = 1;
            else if (m[7:6] == 2'd2) dn = 2;
            else dn = 0;
            if (dn == 1) r.disp = {{8{b[i][7]}}, b[i]};
            else if (dn == 2) r.disp = {b[i+1], b[i]};
            i += dn;
        end
        if (op inside {8'h9A, 8'hEA}) inn = 4;
        else if ((op <= 8'h3F && op[2:0] == 3'd5) || op inside {8'h81, [8'hA0:8'hA3], 8'hA9,
                 [8'hB8:8'hBF], 8'hC2, 8'hCA, 8'hE8, 8'hE9, 8'hC7} ||
                 (op == 8'hF7 && m[5:3] == 3'd0)) inn = 2;
        else if ((op <= 8'h3F && op[2:0] == 3'd4) || op inside {8'h80, 8'h82, 8'h83,
                 [8'h70:8'h7F], 8'hA8, [8'hB0:8'hB7], 8'hCD, 8'hD4, 8'hD5, [8'hE0:8'hE7],
                 8'hEB, 8'hC6} || (op == 8'hF6 && m[5:3] == 3'd0)) inn = 1;
        else inn = 0;
        for (int k = 0; k < inn; k++) r.imm[8*k +: 8] = b[i+k];
        i += inn;
        r.len = (i > 15) ? 4'hF : 4'(i);
        used = i;
        return r;
    endfunction

    function automatic rec_t mk(input logic [7:0] op, input logic [7:0] m, input logic hm,
                                input logic [15:0] d, input logic [31:0] im, input logic sv,
                                input logic [1:0] s, input logic [1:0] rp, input logic lk,
                                input logic [3:0] ln);
        rec_t r;
        r.opcode = op; r.modrm = m; r.has_modrm = hm; r.disp = d; r.imm = im;
        r.segv = sv; r.seg = s; r.rep = rp; r.lock = lk; r.len = ln;
        return r;
    endfunction

    function automatic rec_t actual();
        rec_t r;
        r.opcode = bus.opcode; r.modrm = bus.modrm; r.has_modrm = bus.has_modrm;
        r.disp = bus.disp; r.imm = bus.imm; r.segv = bus.seg_ovr_valid;
        r.seg = bus.seg_ovr; r.rep = bus.rep; r.lock = bus.lock; r.len = bus.inst_len;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic drive_q();
        bus.prefetchEmpty = hold || (pq.size() == 0);
        bus.prefetchTop   = (pq.size() > 0) ? pq[0] : 8'h00;
    endtask

    // One clock: queue model, record compare, and randomized drives.
    task automatic tick();
        rec_t act;
        rec_t junk;
        logic [7:0] jb;
        @(negedge CLKx4);
        if (was_valid && (bus.inst_ack || bus.flush || RESET) && exp_q.size() > 0)
            junk = exp_q.pop_front();
        if (bus.advanceTop) begin
            vectors++;
            if (prev_adv || pq.size() == 0) begin
                errors++;
                $display("FAIL adv_pulse: back_to_back=%0b queue_size=%0d, expected isolated pulse with a byte queued",
                         prev_adv, pq.size());
            end
            if (pq.size() > 0) jb = pq.pop_front();
        end
        prev_adv = bus.advanceTop;
        if (bus.inst_valid) begin
            act = actual();
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL record: got unexpected record %h, expected no valid", act);
            end else if (act !== exp_q[0]) begin
                errors++;
                $display("FAIL record: got %h, expected %h", act, exp_q[0]);
            end
        end
        was_valid = bus.inst_valid;
        if (auto_ack) bus.inst_ack = ($urandom_range(0, 2) == 0);
        if (auto_hold) hold = ($urandom_range(0, 3) == 0);
        drive_q();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic add(input logic [7:0] x);
        dq.push_back(x);
    endtask

    // Push dq as one instruction, pinning the decoder against a literal.
    task automatic directed(input string nm, input rec_t lit);
        logic [7:0] b [32];
        int used;
        rec_t m;
        for (int i = 0; i < 32; i++) b[i] = (i < dq.size()) ? dq[i] : 8'h00;
        m = decode(b, used);
        chk({nm, "_model"}, 128'(m), 128'(lit));
        foreach (dq[i]) pq.push_back(dq[i]);
        exp_q.push_back(lit);
        dq.delete();
        drive_q();
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.inst_valid && n < 200) begin tick(); n++; end
        chk({nm, "_valid_seen"}, 128'(bus.inst_valid), 128'(1'b1));
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || pq.size() != 0) && n < lim) begin tick(); n++; end
        chk({nm, "_drained"}, 128'(exp_q.size() + pq.size()), 128'(0));
    endtask

    task automatic wait_pq_empty(input string nm);
        int n = 0;
        while (pq.size() != 0 && n < 200) begin tick(); n++; end
        chk({nm, "_popped"}, 128'(pq.size()), 128'(0));
    endtask

    task automatic wait_pop(input string nm);
        int n = 0;
        int s = pq.size();
        while (pq.size() == s && n < 100) begin tick(); n++; end
        chk({nm, "_pop"}, 128'(pq.size()), 128'(s - 1));
    endtask

    rec_t nop_lit;
    logic [7:0] rb [32];
    logic [7:0] op;
    int   used;
    rec_t rr;
    logic [7:0] ptab [7];

    initial begin
        ptab[0] = 8'h26; ptab[1] = 8'h2E; ptab[2] = 8'h36; ptab[3] = 8'h3E;
        ptab[4] = 8'hF0; ptab[5] = 8'hF2; ptab[6] = 8'hF3;
        nop_lit = mk(8'h90, 8'h00, 1'b0, 16'h0000, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd1);
        bus.flush = 1'b0;
        bus.inst_ack = 1'b0;
        drive_q();
        run(3);
        chk("reset_outputs", 128'({bus.inst_valid, bus.advanceTop, actual()}), 128'(0));
        RESET = 1'b0;

        // single-byte NOP with explicit ack
        add(8'h90);
        directed("nop", nop_lit);
        wait_valid("nop");
        tick();
        bus.inst_ack = 1'b1;
        tick();
        chk("ack_clears_valid", 128'(bus.inst_valid), 128'(1'b0));
        bus.inst_ack = 1'b0;
        auto_ack = 1'b1;

        add(8'h2E); add(8'h8B); add(8'h46); add(8'hFE);
        directed("cs_mov", mk(8'h8B, 8'h46, 1'b1, 16'hFFFE, 32'h0, 1'b1, 2'd1, 2'd0, 1'b0, 4'd4));
        add(8'hEA); add(8'h00); add(8'h01); add(8'h00); add(8'hF0);
        directed("jmpf", mk(8'hEA, 8'h00, 1'b0, 16'h0000, 32'hF000_0100, 1'b0, 2'd0, 2'd0, 1'b0, 4'd5));
        add(8'hC7); add(8'h06); add(8'h34); add(8'h12); add(8'h78); add(8'h56);
        directed("movw", mk(8'hC7, 8'h06, 1'b1, 16'h1234, 32'h0000_5678, 1'b0, 2'd0, 2'd0, 1'b0, 4'd6));
        wait_drain("basic", 400);

        // rep prefixes with the queue held empty between bytes
        hold = 1'b1;
        add(8'hF3); add(8'hF2); add(8'hA4);
        directed("rep", mk(8'hA4, 8'h00, 1'b0, 16'h0000, 32'h0, 1'b0, 2'd0, 2'b10, 1'b0, 4'd3));
        for (int k = 0; k < 3; k++) begin
            hold = 1'b0;
            drive_q();
            wait_pop("rep");
            hold = 1'b1;
            drive_q();
            for (int c = 0; c < 10; c++) begin
                tick();
                chk("stall_no_pop", 128'(bus.advanceTop), 128'(1'b0));
            end
        end
        hold = 1'b0;
        drive_q();
        wait_drain("rep", 200);

        // length counter saturation
        for (int k = 0; k < 12; k++) add(8'h2E);
        add(8'hF0); add(8'h26);
        add(8'hC7); add(8'h06); add(8'h34); add(8'h12); add(8'h78); add(8'h56);
        directed("sat", mk(8'hC7, 8'h06, 1'b1, 16'h1234, 32'h0000_5678, 1'b1, 2'd0, 2'd0, 1'b1, 4'hF));
        wait_drain("sat", 400);

        // flush an instruction stalled waiting for its immediate
        pq.push_back(8'h81); pq.push_back(8'hC3);
        drive_q();
        wait_pq_empty("flush81");
        run(4);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        add(8'h90);
        directed("after_flush", nop_lit);
        wait_drain("after_flush", 200);

        // hold off ack in DONE with a byte waiting in the queue
        auto_ack = 1'b0;
        bus.inst_ack = 1'b0;
        add(8'h90);
        directed("hold_a", nop_lit);
        add(8'h90);
        directed("hold_b", nop_lit);
        wait_valid("hold");
        run(20);
        chk("done_no_pop", 128'(pq.size()), 128'(1));
        auto_ack = 1'b1;
        wait_drain("hold", 200);

        // flush together with ack
        auto_ack = 1'b0;
        bus.inst_ack = 1'b0;
        add(8'h90);
        directed("flush_ack", nop_lit);
        wait_valid("flush_ack");
        bus.flush = 1'b1;
        bus.inst_ack = 1'b1;
        tick();
        chk("flush_ack_drop", 128'(bus.inst_valid), 128'(1'b0));
        bus.flush = 1'b0;
        bus.inst_ack = 1'b0;
        run(5);

        // reset while waiting for a displacement byte
        pq.push_back(8'h8B); pq.push_back(8'h86);
        drive_q();
        wait_pq_empty("rst_disp");
        run(3);
        chk("pre_reset_opcode", 128'({bus.opcode, bus.has_modrm}), 128'({8'h8B, 1'b1}));
        RESET = 1'b1;
        tick();
        chk("reset_mid_disp", 128'({bus.inst_valid, bus.advanceTop, actual()}), 128'(0));
        RESET = 1'b0;
        tick();

        // randomized instruction stream with random stalls and acks
        auto_ack = 1'b1;
        auto_hold = 1'b1;
        for (int n = 0; n < 120; n++) begin
            for (int i = 0; i < 32; i++) rb[i] = 8'h00;
            used = int'($urandom_range(0, 3));
            for (int j = 0; j < used; j++) rb[j] = ptab[$urandom_range(0, 6)];
            op = 8'(($urandom));
            while (is_prefix(op)) op = 8'(($urandom));
            rb[used] = op;
            for (int j = 1; j < 8; j++) rb[used+j] = 8'(($urandom));
            rr = decode(rb, used);
            for (int j = 0; j < used; j++) pq.push_back(rb[j]);
            exp_q.push_back(rr);
        end
        drive_q();
        wait_drain("random", 20000);
        auto_hold = 1'b0;
        hold = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
